// File: rtl/dsm_pkg.sv
// Shared constants and elaboration helpers for the
// delta-sigma bitstream decimator.
package dsm_pkg;

  typedef enum logic {
    CIC_INTEG,
    CIC_COMB
  } cic_kind_e;

  localparam logic BIT_POS  = 1'b1;
  localparam int   STEP_POS = 1;
  localparam int   STEP_NEG = -1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(
    input int order,
    input int dlog2
  );
    return order * dlog2 + 2;
  endfunction

  function automatic int out_shift(
    input int order,
    input int dlog2,
    input int dw
  );
    return order * dlog2 - (dw - 1);
  endfunction

endpackage

// File: rtl/dsm_cic_stage.sv
// One CIC stage: a wrapping integrator (registered
// output) or a comb (x minus its delayed copy).
module dsm_cic_stage
  import dsm_pkg::*;
#(
  parameter int        WIDTH = 20,
  parameter cic_kind_e KIND  = CIC_INTEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= (KIND == CIC_INTEG) ? q + x : x;
    end
  end

  assign y = (KIND == CIC_INTEG) ? q : x - q;

endmodule

// File: rtl/dsm_bitstream_decimator.sv
// Sinc^N decimator turning a 1-bit delta-sigma stream
// into signed PCM, one sample per 2^DECIM_LOG2 inputs.
module dsm_bitstream_decimator
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM_LOG2 = 6,
  parameter int CIC_ORDER  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_bitstream,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_sat
);

  localparam int ACC_WIDTH = acc_width(CIC_ORDER, DECIM_LOG2);
  localparam int SHIFT = out_shift(CIC_ORDER, DECIM_LOG2, DATA_WIDTH);
  localparam int PRIME_W = clog2(CIC_ORDER + 2);
  localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(CIC_ORDER + 1);
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic signed [ACC_WIDTH-1:0] V_MAX =
    ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] V_MIN =
    ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

  if (CIC_ORDER < 1 || CIC_ORDER > 5 ||
      CIC_ORDER * DECIM_LOG2 < DATA_WIDTH - 1) begin : g_bad_cfg
    $error("dsm_bitstream_decimator: illegal parameter set");
  end

  logic [DECIM_LOG2-1:0] cnt;
  logic [PRIME_W-1:0]    prime;
  logic                  strobe;
  logic [ACC_WIDTH-1:0]  integ [CIC_ORDER+1];
  logic [ACC_WIDTH-1:0]  comb  [CIC_ORDER+1];
  logic signed [ACC_WIDTH-1:0] y;
  logic signed [ACC_WIDTH-1:0] v;
  logic [DATA_WIDTH-1:0] sat_data;
  logic                  sat_flag;

  assign strobe = i_en && (cnt == CNT_LAST);
  assign integ[0] = (i_bitstream == BIT_POS) ?
    ACC_WIDTH'(STEP_POS) : ACC_WIDTH'(STEP_NEG);
  // Combs see the last integrator before this cycle's update
  assign comb[0] = integ[CIC_ORDER];

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_cic
    dsm_cic_stage #(
      .WIDTH(ACC_WIDTH),
      .KIND (CIC_INTEG)
    ) u_int (
      .clk(i_clk),
      .rst(i_rst),
      .en (i_en),
      .x  (integ[k]),
      .y  (integ[k+1])
    );
    dsm_cic_stage #(
      .WIDTH(ACC_WIDTH),
      .KIND (CIC_COMB)
    ) u_comb (
      .clk(i_clk),
      .rst(i_rst),
      .en (strobe),
      .x  (comb[k]),
      .y  (comb[k+1])
    );
  end

  assign y = comb[CIC_ORDER];
  assign v = y >>> SHIFT;

  always_comb begin
    sat_data = v[DATA_WIDTH-1:0];
    sat_flag = 1'b0;
    if (v > V_MAX) begin
      sat_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat_flag = 1'b1;
    end else if (v < V_MIN) begin
      sat_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      prime   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_en) cnt <= cnt + DECIM_LOG2'(1);
      if (strobe) begin
        if (prime == PRIME_DONE) begin
          o_data  <= sat_data;
          o_sat   <= sat_flag;
          o_valid <= 1'b1;
        end else begin
          prime <= prime + PRIME_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dsm_bitstream_decimator.sv
// Bench for dsm_bitstream_decimator: pattern table,
// multi-cycle corner cases and a random convolution model.
module tb_dsm_bitstream_decimator;

  localparam int N    = 3;
  localparam int L    = 6;
  localparam int R    = 1 << L;
  localparam int SH   = N * L - 15;
  localparam int PMAX = 32767;
  localparam int PMIN = -32768;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_bitstream = 1'b0;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_sat;

  dsm_bitstream_decimator dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_bitstream(i_bitstream),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_sat      (o_sat)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  int h[];
  int xs[$];
  logic signed [15:0] exp_data = '0;
  logic exp_sat = 1'b0;
  logic exp_valid = 1'b0;
  logic prev_valid = 1'b0;

  typedef struct {
    string name;
    logic [3:0] pat;
    logic signed [15:0] data;
    logic sat;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(
    input string name,
    input logic signed [31:0] act,
    input logic signed [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Impulse response of ((1 - z^-R)/(1 - z^-1))^N
  function automatic void build_h();
    int tmp[];
    h = new[1];
    h[0] = 1;
    for (int s = 0; s < N; s++) begin
      tmp = new[h.size() + R - 1];
      foreach (tmp[i]) tmp[i] = 0;
      foreach (h[i]) for (int k = 0; k < R; k++) tmp[i+k] += h[i];
      h = tmp;
    end
  endfunction

  // Strobe at sample s sees inputs delayed N by the integrator registers
  function automatic void model_sample(
    input int s,
    output logic signed [15:0] d,
    output logic sat
  );
    longint y;
    longint v;
    y = 0;
    foreach (h[j]) begin
      int idx;
      idx = s - N - j;
      if (idx >= 0) y += longint'(h[j]) * longint'(xs[idx]);
    end
    v = y >>> SH;
    sat = 1'b0;
    if (v > PMAX) begin
      v = PMAX;
      sat = 1'b1;
    end else if (v < PMIN) begin
      v = PMIN;
      sat = 1'b1;
    end
    d = 16'(v);
  endfunction

  task automatic tick(input logic rst, input logic en, input logic b);
    i_rst = rst;
    i_en = en;
    i_bitstream = b;
    @(posedge i_clk);
    #1;
    exp_valid = 1'b0;
    if (rst) begin
      xs.delete();
      exp_data = '0;
      exp_sat = 1'b0;
    end else if (en) begin
      xs.push_back(b ? 1 : -1);
      if (xs.size() % R == 0 && xs.size() / R > N + 1) begin
        model_sample(xs.size() - 1, exp_data, exp_sat);
        exp_valid = 1'b1;
      end
    end
    chk("valid", 32'(o_valid), 32'(exp_valid));
    chk("data", $signed(o_data), exp_data);
    chk("sat", 32'(o_sat), 32'(exp_sat));
    if (o_valid && prev_valid) chk("valid_back2back", 1, 0);
    prev_valid = o_valid;
  endtask

  function automatic logic pat_bit(input logic [3:0] pat);
    int idx;
    idx = 3 - (xs.size() % 4);
    return pat[idx];
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int first;
    int last;
    int cyc;
    logic [15:0] hold;

    build_h();
    tbl[0] = '{"const_ones", 4'b1111, 16'sd32767, 1'b1};
    tbl[1] = '{"const_zeros", 4'b0000, -16'sd32768, 1'b0};
    tbl[2] = '{"alt_1010", 4'b1010, 16'sd0, 1'b0};
    tbl[3] = '{"pat_1110", 4'b1110, 16'sd16384, 1'b0};

    repeat (3) tick(1'b1, 1'b0, 1'b0);
    chk("reset_valid", 32'(o_valid), 0);
    chk("reset_data", $signed(o_data), 0);
    chk("reset_sat", 32'(o_sat), 0);

    foreach (tbl[t]) begin
      tick(1'b1, 1'b1, 1'b1);
      nv = 0;
      first = -1;
      while (xs.size() < 10 * R) begin
        tick(1'b0, 1'b1, pat_bit(tbl[t].pat));
        if (o_valid) begin
          if (first < 0) first = xs.size();
          chk({tbl[t].name, "_data"}, $signed(o_data), tbl[t].data);
          chk({tbl[t].name, "_sat"}, 32'(o_sat), 32'(tbl[t].sat));
          nv++;
        end
      end
      chk({tbl[t].name, "_first"}, first, 5 * R);
      chk({tbl[t].name, "_count"}, nv, 6);
    end

    tick(1'b1, 1'b0, 1'b0);
    nv = 0;
    last = -1;
    cyc = 0;
    while (nv < 4 && cyc < 2000) begin
      tick(1'b0, (cyc % 2) == 0, (xs.size() % 2) == 0);
      cyc++;
      if (o_valid) begin
        if (last >= 0) chk("half_en_spacing", cyc - last, 2 * R);
        chk("half_en_data", $signed(o_data), 0);
        last = cyc;
        nv++;
      end
    end
    chk("half_en_valids", nv, 4);

    tick(1'b1, 1'b0, 1'b0);
    while (xs.size() < 350) tick(1'b0, 1'b1, pat_bit(4'b1110));
    hold = o_data;
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 1'b0, 1'($urandom));
      if (o_valid) nv++;
    end
    chk("gap_no_valid", nv, 0);
    chk("gap_hold", $signed(o_data), $signed(hold));
    while (xs.size() < 7 * R) begin
      tick(1'b0, 1'b1, pat_bit(4'b1110));
      if (o_valid) begin
        nv++;
        chk("gap_after_data", $signed(o_data), 16384);
      end
    end
    chk("gap_after_valids", nv, 2);

    tick(1'b1, 1'b0, 1'b0);
    while (xs.size() < 400) tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk("midrst_valid", 32'(o_valid), 0);
    chk("midrst_data", $signed(o_data), 0);
    chk("midrst_sat", 32'(o_sat), 0);
    first = -1;
    for (int k = 1; k <= 400 && first < 0; k++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (o_valid) first = k;
    end
    chk("midrst_next_valid", first, 5 * R);

    tick(1'b1, 1'b0, 1'b0);
    nv = 0;
    cyc = 0;
    while (xs.size() < 10000 && cyc < 20000) begin
      tick(1'b0, ($urandom % 8) != 0, 1'($urandom));
      cyc++;
      if (o_valid) nv++;
    end
    chk("rand_bits", xs.size(), 10000);
    chk("rand_valids", nv, 10000 / R - (N + 1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
